// File: rtl/idu_pipe.sv
// Instruction decode stage: one-entry pipeline register between IFU and EXU.
// Decodes RV32I/RV64I formats, immediates and flags, and counts handed-off bundles.
module idu_pipe #(
  parameter int XLEN  = 32,
  parameter bit RV32E = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [XLEN-1:0] in_pc,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [6:0]      out_opcode,
  output logic [2:0]      out_funct3,
  output logic [6:0]      out_funct7,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt,
  output logic            out_rd_we,
  output logic            out_illegal,
  output logic            out_ecall,
  output logic            out_ebreak,
  output logic            ebreak_event,
  output logic [31:0]     decode_count
);

  localparam logic [2:0] FMT_NONE = 3'd0;
  localparam logic [2:0] FMT_R    = 3'd1;
  localparam logic [2:0] FMT_I    = 3'd2;
  localparam logic [2:0] FMT_S    = 3'd3;
  localparam logic [2:0] FMT_B    = 3'd4;
  localparam logic [2:0] FMT_U    = 3'd5;
  localparam logic [2:0] FMT_J    = 3'd6;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_OP     = 7'b0110011;

  logic [6:0]         opcode;
  logic [2:0]         funct3;
  logic [4:0]         rs1, rs2, rd;
  logic [2:0]         fmt;
  logic signed [31:0] imm32;
  logic [XLEN-1:0]    imm;
  logic               illegal, idx_bad, rd_we, is_ecall, is_ebreak;
  logic               load, handoff;

  assign opcode = in_inst[6:0];
  assign funct3 = in_inst[14:12];
  assign rs1    = in_inst[19:15];
  assign rs2    = in_inst[24:20];
  assign rd     = in_inst[11:7];

  always_comb begin
    fmt = FMT_NONE;
    case (opcode)
      OP_LUI, OP_AUIPC:                      fmt = FMT_U;
      OP_JAL:                                fmt = FMT_J;
      OP_JALR, OP_LOAD, OP_OPIMM, OP_SYSTEM: fmt = FMT_I;
      OP_STORE:                              fmt = FMT_S;
      OP_BRANCH:                             fmt = FMT_B;
      OP_OP:                                 fmt = FMT_R;
      default:                               fmt = FMT_NONE;
    endcase
  end

  // Immediates are assembled at 32 bits and sign-extended to XLEN by the signed cast.
  always_comb begin
    imm32 = '0;
    case (fmt)
      FMT_I:   imm32 = {{20{in_inst[31]}}, in_inst[31:20]};
      FMT_S:   imm32 = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
      FMT_B:   imm32 = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25],
                        in_inst[11:8], 1'b0};
      FMT_U:   imm32 = {in_inst[31:12], 12'b0};
      FMT_J:   imm32 = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20],
                        in_inst[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end

  assign imm = XLEN'(imm32);

  // Only the register indices a format actually uses are range-checked under RV32E.
  always_comb begin
    idx_bad = 1'b0;
    if (RV32E) begin
      case (fmt)
        FMT_R:        idx_bad = rs1[4] | rs2[4] | rd[4];
        FMT_I:        idx_bad = rs1[4] | rd[4];
        FMT_S, FMT_B: idx_bad = rs1[4] | rs2[4];
        FMT_U, FMT_J: idx_bad = rd[4];
        default:      idx_bad = 1'b0;
      endcase
    end
  end

  always_comb begin
    illegal = 1'b0;
    if (fmt == FMT_NONE)                                        illegal = 1'b1;
    if (in_inst[1:0] != 2'b11)                                  illegal = 1'b1;
    if (opcode == OP_JALR && funct3 != 3'b000)                  illegal = 1'b1;
    if (opcode == OP_BRANCH && (funct3 == 3'b010 || funct3 == 3'b011))
                                                                illegal = 1'b1;
    if (opcode == OP_STORE && funct3 > 3'b010)                  illegal = 1'b1;
    if (idx_bad)                                                illegal = 1'b1;
  end

  assign is_ecall  = (in_inst == 32'h0000_0073);
  assign is_ebreak = (in_inst == 32'h0010_0073);
  assign rd_we     = (fmt == FMT_R || fmt == FMT_I || fmt == FMT_U || fmt == FMT_J) &&
                     (rd != 5'd0) && (opcode != OP_SYSTEM) && !illegal;

  assign in_ready = !out_valid || out_ready || flush;
  assign load     = in_valid && in_ready && !flush;
  assign handoff  = out_valid && out_ready && !flush;

  // Flush drops the held bundle; payload is left as-is since out_valid qualifies it.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_pc      <= '0;
      out_opcode  <= '0;
      out_funct3  <= '0;
      out_funct7  <= '0;
      out_rs1     <= '0;
      out_rs2     <= '0;
      out_rd      <= '0;
      out_imm     <= '0;
      out_fmt     <= FMT_NONE;
      out_rd_we   <= 1'b0;
      out_illegal <= 1'b0;
      out_ecall   <= 1'b0;
      out_ebreak  <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (load) begin
      out_valid   <= 1'b1;
      out_pc      <= in_pc;
      out_opcode  <= opcode;
      out_funct3  <= funct3;
      out_funct7  <= in_inst[31:25];
      out_rs1     <= rs1;
      out_rs2     <= rs2;
      out_rd      <= rd;
      out_imm     <= imm;
      out_fmt     <= fmt;
      out_rd_we   <= rd_we;
      out_illegal <= illegal;
      out_ecall   <= is_ecall;
      out_ebreak  <= is_ebreak;
    end else if (handoff) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      decode_count <= 32'd0;
    end else if (handoff) begin
      decode_count <= decode_count + 32'd1;
    end
  end

  assign ebreak_event = handoff && out_ebreak && !rst;

endmodule

// File: doc/idu_pipe.md
IDU_PIPE -- requirements
Module: idu_pipe

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning datapath/PC/immediate width (32 or 64).
REQ-002 SHALL have parameter RV32E, default 0, meaning 1 restricts register indices to x0..x15.
REQ-003 clk  in  1  single clock, all state updates on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 in_valid  in  1  upstream (IFU) instruction valid.
REQ-006 in_ready  out  1  stage can accept an instruction this cycle.
REQ-007 in_inst  in  32  raw instruction word.
REQ-008 in_pc  in  XLEN  PC of in_inst.
REQ-009 flush  in  1  kill held and incoming instruction.
REQ-010 out_valid  out  1  decoded bundle valid toward EXU.
REQ-011 out_ready  in  1  EXU accepts bundle.
REQ-012 out_pc  out  XLEN; out_opcode out 7; out_funct3 out 3; out_funct7 out 7: registered copies/fields.
REQ-013 out_rs1, out_rs2, out_rd  out  5 each  register indices inst[19:15], inst[24:20], inst[11:7].
REQ-014 out_imm  out  XLEN  sign-extended immediate.
REQ-015 out_fmt  out  3  format code: 0 NONE, 1 R, 2 I, 3 S, 4 B, 5 U, 6 J.
REQ-016 out_rd_we  out  1; out_illegal out 1; out_ecall out 1; out_ebreak out 1: decoded flags.
REQ-017 ebreak_event  out  1  one-cycle pulse when an ebreak bundle is handed off.
REQ-018 decode_count  out  32  number of bundles handed off since reset.

Function
REQ-019 SHALL be a one-entry pipeline register: in_ready = !out_valid || out_ready || flush.
REQ-020 SHALL load decoded fields when in_valid && in_ready && !flush, setting out_valid=1 next cycle (latency 1).
REQ-021 SHALL clear out_valid when out_valid && out_ready and no new load in the same cycle; load+handoff same cycle keeps out_valid=1 with new data.
REQ-022 SHALL hold all out_* payload stable while out_valid && !out_ready && !flush.
REQ-023 flush SHALL dominate: out_valid=0 next cycle, a concurrent input is consumed and discarded, no ebreak_event, no count increment.
REQ-024 Format by opcode: 0110111/0010111 U; 1101111 J; 1100111, 0000011, 0010011, 1110011 I; 0100011 S; 1100011 B; 0110011 R; any other NONE.
REQ-025 Immediates, sign-extended from inst[31] to XLEN: I {inst[31:20]}; S {inst[31:25],inst[11:7]}; B {inst[31],inst[7],inst[30:25],inst[11:8],0}; U {inst[31:12],12'b0}; J {inst[31],inst[19:12],inst[20],inst[30:21],0}; R/NONE 0.
REQ-026 out_illegal=1 when fmt NONE, inst[1:0]!=2'b11, JALR funct3!=000, BRANCH funct3 in {010,011}, STORE funct3>010, or RV32E=1 and any used index (rs1/rs2/rd per format) >=16.
REQ-027 out_ebreak=1 iff inst==32'h00100073; out_ecall=1 iff inst==32'h00000073.
REQ-028 out_rd_we=1 for R/I/U/J with rd!=0, excluding SYSTEM and illegal; 0 otherwise.
REQ-029 ebreak_event = out_valid && out_ready && out_ebreak && !flush, exactly one cycle per ebreak bundle.
REQ-030 decode_count SHALL increment by 1 on each handoff (out_valid && out_ready && !flush), wrapping 0xFFFFFFFF -> 0.

Reset
REQ-031 On rst=1 at a clock edge: out_valid=0, all payload outputs 0, out_fmt=0, flags 0, decode_count=0; an in-flight bundle is dropped.
REQ-032 ebreak_event SHALL be 0 during and in the cycle after reset; rst SHALL override flush and in_valid.

Verification
REQ-033 in_inst=0x00500093 (addi x1,x0,5), out_ready=1 -> next cycle out_valid=1, fmt=2, rd=1, rs1=0, imm=5, rd_we=1, illegal=0.
REQ-034 out_ready=0, two back-to-back valids -> first loads, in_ready=0 after, payload stable; raising out_ready loads second same cycle, decode_count=1.
REQ-035 in_inst=0xFE208EE3 (beq x1,x2,-4) -> fmt=4, imm=0xFFFFFFFC, rs1=1, rs2=2, rd_we=0.
REQ-036 in_inst=0x00100073, out_ready=1 -> out_ebreak=1, ebreak_event high exactly one cycle, rd_we=0.
REQ-037 out_valid=1, out_ready=0, flush=1 with in_valid=1 -> out_valid=0 next cycle, input dropped, decode_count unchanged.
REQ-038 RV32E=1, in_inst=0x01000833 (add x16,x0,x16) -> out_illegal=1, out_rd_we=0.
